fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the width-converting FIFO (16-bit write, 8-bit read) between two producers.
- Round-robin grant with burst locking: a granted producer keeps the port for up to MAX_BURST words, then yields to the other producer if it is requesting.
- Honours FIFO `full` so no write is ever issued into a full FIFO.
- Sits directly in front of the FIFO's `wr`/`w_data` inputs. The FIFO's `rd`/`empty` side is untouched.

Parameters:
- WRITE_WIDTH, 16, width of producer data and FIFO write data.
- MAX_BURST, 4, maximum consecutive words written by one producer while the other is waiting (>=1).

Ports:
- clk  input  1  system clock, all state on posedge
- reset  input  1  asynchronous, active-high reset
- req0  input  1  producer 0 has a valid word on data0; held until ack0
- data0  input  WRITE_WIDTH  producer 0 write word
- ack0  output  1  word on data0 is written into the FIFO at this clock edge
- req1  input  1  producer 1 request, same rules as req0
- data1  input  WRITE_WIDTH  producer 1 write word
- ack1  output  1  producer 1 acknowledge
- full  input  1  FIFO full flag
- wr  output  1  FIFO write enable
- w_data  output  WRITE_WIDTH  FIFO write data
- grant  output  2  one-hot current owner (01 = P0, 10 = P1, 00 = idle)

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE, burst_cnt = 0, last_served = 1 (so P0 wins the first tie).
  - grant = 00, wr = 0, ack0 = ack1 = 0, w_data = 0.
- Registered state is {IDLE, SERVE0, SERVE1}, burst_cnt ($clog2(MAX_BURST+1) bits) and last_served.
- Outputs are combinational from state and inputs:
  - SERVEn: grant one-hot n; wr = reqn & ~full; ackn = wr; w_data = datan; the other ack = 0.
  - IDLE: wr = 0, w_data = 0, no acks.
- The FIFO and the producer both consume the word at the same posedge where wr/ackn = 1. Zero added latency once granted.
- IDLE transitions:
  - req0 & req1: go to the producer != last_served.
  - Only one req: go to that producer.
  - Neither: stay in IDLE.
  - Entering SERVE clears burst_cnt. IDLE never writes, so the first grant costs one bubble cycle.
- SERVEn transitions (evaluated every edge):
  - Write this cycle: burst_cnt += 1.
  - reqn = 0: if the other producer requests, go to SERVEother with cnt = 0; else go to IDLE. last_served = n.
  - Write this cycle and burst_cnt+1 == MAX_BURST:
    - Other producer requesting: go to SERVEother, cnt = 0, last_served = n.
    - Other producer not requesting: stay in SERVEn, cnt = 0.
  - A direct SERVE0 <-> SERVE1 handoff has no bubble: a write can occur on the very next cycle.
- full = 1: no write and no ack. burst_cnt holds and grant holds; full stalls are not charged to the burst. A req drop while full is still honoured.
- A producer must not change datan while reqn = 1 and ackn = 0. The arbiter does not check this.
- reset asserted mid-burst: outputs drop to their reset values immediately (asynchronously). Any partially-asserted write is not guaranteed.
- No word is duplicated or lost: each ack corresponds to exactly one wr.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum typedef (IDLE, SERVE0, SERVE1);
  - a localparam for the burst counter width.
- No sub-module is needed. The FIFO is instantiated alongside this block at the next level, not inside it.

Test Plan:
- Single producer: req0 = 1 with data0 0x0100, 0x0201, 0x0402, ..., full = 0.
  - grant goes 00 -> 01 after one cycle.
  - Thereafter wr = ack0 = 1 every cycle.
  - w_data follows data0.
  - FIFO reads back bytes 01,00,02,01,04,02.
- Contention, MAX_BURST = 4: req0 and req1 held high from reset.
  - Write order is P0 x4, P1 x4, P0 x4.
  - Grant switches with no idle cycle between bursts.
- Full stall: SERVE0 with burst_cnt = 2, full = 1 for 3 cycles.
  - wr = ack0 = 0 and grant stays 01 during the stall.
  - After full drops, exactly 2 more P0 words precede the switch to P1.
- Request drop: P1 deasserts req1 after 2 words while req0 = 1.
  - Next cycle grant = 01 and wr = 1 (P0).
  - If neither requests, grant = 00.
- Lone burst continuation: only req1 active for 10 words.
  - grant stays 10 and wr stays 1 continuously; the MAX_BURST wrap does not stall.
- Async reset mid-burst: assert reset between edges while SERVE1.
  - grant, wr and ack1 go to 0 immediately.
  - After release, a simultaneous req0 and req1 grants P0 first.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type and counter sizing for the FIFO write-port arbiter
package fifo_arb_pkg;
    typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} arb_state_t;
    localparam int DEFAULT_MAX_BURST = 4;
    localparam int BURST_CNT_W = $clog2(DEFAULT_MAX_BURST + 1);
    function automatic int burst_cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction
endpackage

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-locked sharing of one FIFO write port between two producers
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WRITE_WIDTH = 16,
    parameter int MAX_BURST   = DEFAULT_MAX_BURST
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0,
    input  logic [WRITE_WIDTH-1:0] data0,
    output logic                   ack0,
    input  logic                   req1,
    input  logic [WRITE_WIDTH-1:0] data1,
    output logic                   ack1,
    input  logic                   full,
    output logic                   wr,
    output logic [WRITE_WIDTH-1:0] w_data,
    output logic [1:0]             grant
);
    localparam int CW = burst_cnt_width(MAX_BURST);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
    arb_state_t state_q, state_d, other;
    logic [CW-1:0] cnt_q, cnt_d;
    logic last_q, last_d;
    logic serving, own_req, oth_req, burst_end;
    assign serving   = state_q != IDLE;
    assign own_req   = state_q == SERVE1 ? req1 : req0;
    assign oth_req   = state_q == SERVE1 ? req0 : req1;
    assign other     = state_q == SERVE1 ? SERVE0 : SERVE1;
    assign wr        = serving & own_req & ~full;
    assign burst_end = wr & (cnt_q == CNT_LAST);
    assign ack0      = wr & (state_q == SERVE0);
    assign ack1      = wr & (state_q == SERVE1);
    assign grant     = {state_q == SERVE1, state_q == SERVE0};
    assign w_data    = state_q == SERVE0 ? data0 : state_q == SERVE1 ? data1 : '0;
    // Full stalls leave cnt_q untouched; only real writes are charged to the burst.
    always_comb begin
        state_d = state_q;
        cnt_d   = wr ? cnt_q + 1'b1 : cnt_q;
        last_d  = last_q;
        if (!serving) begin
            cnt_d   = '0;
            state_d = (req0 & req1) ? (last_q ? SERVE0 : SERVE1) : req0 ? SERVE0 : req1 ? SERVE1 : IDLE;
        end else if (!own_req || burst_end) begin
            cnt_d   = '0;
            state_d = oth_req ? other : own_req ? state_q : IDLE;
            last_d  = (oth_req || !own_req) ? (state_q == SERVE1) : last_q;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench with a per-cycle reference model of the arbitration rules
module tb_fifo_wr_arbiter;
    localparam int W  = 16;
    localparam int MB = 4;
    logic clk = 0, reset = 1, full = 0;
    logic req0, req1, ack0, ack1, wr;
    logic [W-1:0] data0, data1, w_data;
    logic [1:0] grant;
    logic rq[2] = '{1'b0, 1'b0};
    logic [W-1:0] dt[2] = '{16'h0, 16'h0};
    logic ack_s[2] = '{1'b0, 1'b0};
    int left[2] = '{0, 0};
    int rate[2] = '{100, 100};
    int full_pct = 0;
    bit pat_on = 0;
    int pat_k = 0;
    int n_cmp = 0, n_err = 0;
    logic [W-1:0] exp_q0[$], exp_q1[$];
    int wr_log[$];
    int m_own = -1, m_run = 0, m_last = 1;
    logic m_w;
    logic [1:0] e_grant;
    logic [W-1:0] e_data;
    assign req0 = rq[0];
    assign req1 = rq[1];
    assign data0 = dt[0];
    assign data1 = dt[1];
    always #5 clk = ~clk;
    fifo_wr_arbiter #(.WRITE_WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .full(full), .wr(wr), .w_data(w_data), .grant(grant)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // Monitor: compares DUT outputs with the model, pops the scoreboard on each write,
    // then advances the model with the inputs the coming edge will see.
    always @(negedge clk) begin
        if (reset) begin
            m_own = -1;
            m_run = 0;
            m_last = 1;
            ack_s[0] = 1'b0;
            ack_s[1] = 1'b0;
            check("reset_grant", 32'(grant), 32'd0);
            check("reset_wr", 32'(wr), 32'd0);
            check("reset_acks", 32'({ack1, ack0}), 32'd0);
            check("reset_wdata", 32'(w_data), 32'd0);
        end else begin
            m_w = ((m_own == 0 && req0) || (m_own == 1 && req1)) && !full;
            e_grant = m_own == 0 ? 2'b01 : m_own == 1 ? 2'b10 : 2'b00;
            e_data = m_own == 0 ? data0 : m_own == 1 ? data1 : '0;
            check("grant", 32'(grant), 32'(e_grant));
            check("wr", 32'(wr), 32'(m_w));
            check("ack0", 32'(ack0), 32'(m_w && m_own == 0));
            check("ack1", 32'(ack1), 32'(m_w && m_own == 1));
            check("w_data", 32'(w_data), 32'(e_data));
            ack_s[0] = ack0;
            ack_s[1] = ack1;
            if (m_w) begin
                wr_log.push_back(m_own);
                if (m_own == 0) begin
                    check("sb_q0_nonempty", 32'(exp_q0.size() != 0), 32'd1);
                    if (exp_q0.size() != 0) check("sb_data0", 32'(w_data), 32'(exp_q0.pop_front()));
                end else begin
                    check("sb_q1_nonempty", 32'(exp_q1.size() != 0), 32'd1);
                    if (exp_q1.size() != 0) check("sb_data1", 32'(w_data), 32'(exp_q1.pop_front()));
                end
            end
            if (m_own < 0) begin
                m_own = (req0 && req1) ? 1 - m_last : req0 ? 0 : req1 ? 1 : -1;
                m_run = 0;
            end else if (!(m_own == 0 ? req0 : req1)) begin
                m_last = m_own;
                m_own = (m_own == 0 ? req1 : req0) ? 1 - m_own : -1;
                m_run = 0;
            end else if (m_w) begin
                m_run++;
                if (m_run == MB) begin
                    m_run = 0;
                    if (m_own == 0 ? req1 : req0) begin
                        m_last = m_own;
                        m_own = 1 - m_own;
                    end
                end
            end
        end
    end
    // Producers hold a word until acked, then optionally present the next one.
    task automatic step();
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (rq[p] && ack_s[p]) rq[p] = 1'b0;
            if (!rq[p] && left[p] > 0 && $urandom_range(0, 99) < rate[p]) begin
                if (p == 0 && pat_on) begin
                    dt[p] = {8'(1 << pat_k), pat_k == 0 ? 8'h00 : 8'(1 << (pat_k - 1))};
                    pat_k++;
                end else dt[p] = W'($urandom);
                if (p == 0) exp_q0.push_back(dt[p]);
                else exp_q1.push_back(dt[p]);
                left[p]--;
                rq[p] = 1'b1;
            end
        end
        full = $urandom_range(0, 99) < full_pct;
    endtask
    task automatic clear_stim();
        rq[0] = 1'b0;
        rq[1] = 1'b0;
        left[0] = 0;
        left[1] = 0;
        exp_q0.delete();
        exp_q1.delete();
        full = 1'b0;
        full_pct = 0;
    endtask
    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        clear_stim();
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        wr_log.delete();
    endtask
    task automatic wait_idle(input string name, input int bound);
        int i = 0;
        while ((left[0] > 0 || left[1] > 0 || rq[0] || rq[1]) && i < bound) begin
            step();
            i++;
        end
        check({name, "_drained"}, 32'(rq[0] | rq[1]), 32'd0);
        check({name, "_sb_left"}, 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    endtask
    task automatic check_log(input string name, input int exp[$]);
        check({name, "_count"}, 32'(wr_log.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < wr_log.size(); i++)
            check({name, "_order"}, 32'(wr_log[i]), 32'(exp[i]));
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int exp[$];
        int i;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        // Single producer with the byte-walking pattern
        pat_on = 1;
        left[0] = 6;
        wait_idle("single", 100);
        exp = '{0, 0, 0, 0, 0, 0};
        check_log("single", exp);
        pat_on = 0;
        // Contention from reset: P0 wins the first tie
        do_reset();
        left[0] = 8;
        left[1] = 4;
        wait_idle("contend", 100);
        exp = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        check_log("contend", exp);
        // Full stall after two P0 words
        do_reset();
        left[0] = 8;
        left[1] = 4;
        i = 0;
        while (wr_log.size() < 2 && i < 50) begin
            step();
            i++;
        end
        check("stall_reached", 32'(wr_log.size()), 32'd2);
        full_pct = 100;
        full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #3;
            check("stall_grant", 32'(grant), 32'd1);
            check("stall_wr", 32'(wr), 32'd0);
            check("stall_ack0", 32'(ack0), 32'd0);
            if (k == 2) full_pct = 0;
            step();
        end
        wait_idle("stall", 100);
        exp = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        check_log("stall", exp);
        // P1 drops after two words while P0 waits
        do_reset();
        left[1] = 2;
        step();
        left[0] = 3;
        wait_idle("drop", 100);
        repeat (2) step();
        exp = '{1, 1, 0, 0, 0};
        check_log("drop", exp);
        check("drop_idle_grant", 32'(grant), 32'd0);
        // Lone producer keeps the port across burst wraps
        do_reset();
        left[1] = 10;
        wait_idle("lone", 100);
        exp = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        check_log("lone", exp);
        // Asynchronous reset in the middle of a P1 burst
        do_reset();
        left[1] = 20;
        i = 0;
        while (wr_log.size() < 3 && i < 50) begin
            step();
            i++;
        end
        #2 reset = 1'b1;
        #1;
        check("async_grant", 32'(grant), 32'd0);
        check("async_wr", 32'(wr), 32'd0);
        check("async_ack1", 32'(ack1), 32'd0);
        clear_stim();
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        wr_log.delete();
        left[0] = 2;
        left[1] = 2;
        wait_idle("post_reset", 100);
        exp = '{0, 0, 1, 1};
        check_log("post_reset", exp);
        // Randomized traffic with random full
        do_reset();
        rate[0] = 60;
        rate[1] = 45;
        left[0] = 300;
        left[1] = 300;
        full_pct = 25;
        wait_idle("random", 5000);
        check("random_writes", 32'(wr_log.size()), 32'd600);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
